uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional parity bit is built only when the UART_TX_PARITY_EN macro is defined.
module uart_tx #(
    parameter int Clkperbaud = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ctrl,
    input  logic [7:0] tx_byte,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = (Clkperbaud > 1) ? $clog2(Clkperbaud) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(Clkperbaud - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATAOUT = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        CLEAN   = 3'd5
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    byte_q;
    logic          tx_serial_q;
    logic          tx_busy_q;
    logic          tx_done_q;

    logic          cnt_last;
    logic [2:0]    bit_idx_d;
    logic [CW-1:0] cnt_d;

    assign cnt_last  = (cnt_q == CNT_LAST);
    assign bit_idx_d = bit_idx_q + 3'd1;
    assign cnt_d     = cnt_q + CW'(1);

    // Every bit period runs the counter 0..Clkperbaud-1; the expiry edge both
    // changes state and loads the next line level, so no bit is ever shortened.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_q      <= '0;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_serial_q <= 1'b1;
                    tx_busy_q   <= 1'b0;
                    cnt_q       <= '0;
                    if (tx_ctrl) begin
                        byte_q      <= tx_byte;
                        bit_idx_q   <= '0;
                        tx_serial_q <= 1'b0;
                        tx_busy_q   <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (cnt_last) begin
                        cnt_q       <= '0;
                        tx_serial_q <= byte_q[0];
                        state_q     <= DATAOUT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATAOUT: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_serial_q <= ^byte_q;
                            state_q     <= PARITY;
`else
                            tx_serial_q <= 1'b1;
                            state_q     <= STOP;
`endif
                        end else begin
                            bit_idx_q   <= bit_idx_d;
                            tx_serial_q <= byte_q[bit_idx_d];
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        cnt_q       <= '0;
                        tx_serial_q <= 1'b1;
                        state_q     <= STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                STOP: begin
                    tx_serial_q <= 1'b1;
                    if (cnt_last) begin
                        cnt_q     <= '0;
                        tx_done_q <= 1'b1;
                        state_q   <= CLEAN;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                CLEAN: begin
                    tx_serial_q <= 1'b1;
                    tx_busy_q   <= 1'b0;
                    cnt_q       <= '0;
                    bit_idx_q   <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    tx_serial_q <= 1'b1;
                    tx_busy_q   <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: compares the line, busy and done outputs each cycle
// against a frame model built from the bit sequence of a UART character.
module tb_uart_tx;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_ctrl;
    logic [7:0] tx_byte;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx #(.Clkperbaud(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_ctrl  (tx_ctrl),
        .tx_byte  (tx_byte),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Expected {serial, busy, done} k cycles after the acceptance edge (k >= 1).
    function automatic logic [2:0] model(input logic [7:0] b, input int k);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        if (k <= NB * C)      return {bits[(k-1)/C], 1'b1, 1'b0};
        else if (k == FRAME)  return 3'b111;
        else                  return 3'b100;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tx_ctrl = 1'b0;
        tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_initial got s/b/d=%b expected 100", {tx_serial, tx_busy, tx_done});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_idle got s/b/d=%b expected 100", {tx_serial, tx_busy, tx_done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] b);
        logic [2:0] exp;
        tx_byte = b;
        tx_ctrl = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FRAME + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tx_ctrl = 1'b0;
                tx_byte = ~b;
            end
            exp = model(b, k);
            n_cmp++;
            if ({tx_serial, tx_busy, tx_done} !== exp) begin
                n_err++;
                $display("FAIL frame_%02h k=%0d got s/b/d=%b expected %b", b, k,
                         {tx_serial, tx_busy, tx_done}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        tx_byte = 8'h3C;
        tx_ctrl = 1'b1;
        @(posedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= FRAME + 1; k++) begin
                @(negedge clk);
                if (k == 3) tx_byte = 8'hC3;
                if (k == FRAME - 5) tx_byte = (f == 0) ? 8'h3C : 8'hC3;
                if (f == 1 && k == 5) tx_ctrl = 1'b0;
                exp = model(8'h3C, k);
                n_cmp++;
                if ({tx_serial, tx_busy, tx_done} !== exp) begin
                    n_err++;
                    $display("FAIL b2b_frame%0d k=%0d got s/b/d=%b expected %b", f, k,
                             {tx_serial, tx_busy, tx_done}, exp);
                end
            end
            // With tx_ctrl still high, the IDLE cycle above is the acceptance cycle.
            if (f == 0) @(posedge clk);
        end
        repeat (C * 3) begin
            @(negedge clk);
            n_cmp++;
            if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
                n_err++;
                $display("FAIL b2b_tail got s/b/d=%b expected 100", {tx_serial, tx_busy, tx_done});
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [2:0] exp;
        tx_byte = 8'hFF;
        tx_ctrl = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4 * C + 2; k++) begin
            @(negedge clk);
            if (k == 1) tx_ctrl = 1'b0;
            exp = model(8'hFF, k);
            n_cmp++;
            if ({tx_serial, tx_busy, tx_done} !== exp) begin
                n_err++;
                $display("FAIL midrst_pre k=%0d got s/b/d=%b expected %b", k,
                         {tx_serial, tx_busy, tx_done}, exp);
            end
        end
        // Line is high during bit 3 of 8'hFF; busy is the visible proof of abort.
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
            n_err++;
            $display("FAIL midrst_edge got s/b/d=%b expected 100", {tx_serial, tx_busy, tx_done});
        end
        rst = 1'b0;
        for (int k = 0; k < FRAME + 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
                n_err++;
                $display("FAIL midrst_after k=%0d got s/b/d=%b expected 100", k,
                         {tx_serial, tx_busy, tx_done});
            end
        end
    endtask

    task automatic test_ctrl_with_rst();
        tx_byte = 8'h00;
        tx_ctrl = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        tx_ctrl = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 2 * C; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
                n_err++;
                $display("FAIL ctrl_with_rst k=%0d got s/b/d=%b expected 100", k,
                         {tx_serial, tx_busy, tx_done});
            end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_frame(b);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        test_frame(8'h07);
        test_frame(8'h03);
        test_frame(8'h00);
        test_frame(8'hFF);
        test_back_to_back();
        test_reset_midframe();
        test_ctrl_with_rst();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
